branch_pred_table: RTL and testbench
====================================

Name: branch_pred_table

Overview:
Direct-mapped table of one-bit taken/not-taken predictors, indexed by fetch PC.
- Fetch-side lookup returns a prediction and records it in an in-order in-flight FIFO.
- Execute-side resolve pops the oldest in-flight entry, writes the actual outcome into the table, and flags a mispredict.
- Sits between fetch (lookup) and execute (resolve); it is the storage and bookkeeping around per-branch one-bit predictor state.

Parameters:
- PC_WIDTH, 32, fetch PC width in bits.
- INDEX_BITS, 6, log2 of table entries (64 entries).
- FIFO_DEPTH, 4, in-flight prediction capacity; must be a power of 2 and ≥2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- lookup_valid  in  1  fetch presents a branch PC this cycle.
- lookup_pc  in  PC_WIDTH  branch PC.
- lookup_ready  out  1  FIFO can accept a lookup.
- pred_taken  out  1  prediction for lookup_pc (combinational).
- resolve_valid  in  1  execute resolves the oldest in-flight branch.
- resolve_taken  in  1  actual branch outcome.
- flush  in  1  discard all in-flight predictions.
- mispredict  out  1  registered one-cycle pulse.
- resolve_err  out  1  registered one-cycle pulse: resolve arrived with FIFO empty.
- inflight_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous, active-high.
  - Reset forces every table entry to 0 (not-taken) and empties the FIFO.
  - Reset drives mispredict=0, resolve_err=0 and inflight_count=0, so lookup_ready=1 after reset.
  - Reset asserted mid-operation discards all in-flight state immediately, without waiting for a clock edge.
- Index: idx = lookup_pc[INDEX_BITS+1:2]; the low 2 bits are ignored.
- pred_taken = table[idx] from the current registered table contents.
  - No bypass: a resolve that writes the same index in the same cycle is seen by lookups only from the next cycle.
- lookup_ready = (inflight_count < FIFO_DEPTH).
  - It is not relaxed by a same-cycle resolve; lookup_ready is 0 when full even if resolve_valid=1.
- Push: when lookup_valid & lookup_ready & ~flush, {idx, pred_taken} is written at the tail on the clock edge.
  - lookup_valid while not ready is dropped; there is no internal retry.
- Pop: when resolve_valid and FIFO not empty, the head entry {h_idx, h_pred} is removed on the clock edge.
  - table[h_idx] <= resolve_taken.
  - mispredict <= (h_pred != resolve_taken) for exactly one cycle; otherwise it returns to 0.
- Empty resolve: resolve_valid with FIFO empty.
  - No table write, no pop; mispredict stays 0.
  - resolve_err <= 1 for one cycle.
- Simultaneous push and pop (not full): both occur; occupancy is unchanged; head and tail pointers each advance.
- Flush:
  - A same-cycle resolve is processed first: table write, mispredict and resolve_err are evaluated as normal.
  - The FIFO is then cleared (count=0, pointers reset to 0).
  - A same-cycle lookup is not pushed.
  - Table contents are retained across flush.
- Pointers: head and tail are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
  - Occupancy is tracked by a separate counter so full and empty are unambiguous.
- Latency:
  - Prediction is 0-cycle, combinational.
  - Table update is visible 1 cycle after resolve.
  - mispredict and resolve_err are asserted in the cycle after the resolve.

Test Plan:
- Reset, then lookup pc=0x40 (idx 16) -> pred_taken=0, inflight_count=1. Resolve taken=1 -> next cycle mispredict=1, and a new lookup of 0x40 returns pred_taken=1.
- Aliasing: pc=0x40 and pc=0x140 (both idx 16); resolve 0x40 taken -> lookup 0x140 returns 1. Resolve 0x140 not-taken -> lookup 0x40 returns 0.
- Fill the FIFO with 4 lookups -> lookup_ready=0. A 5th lookup_valid is dropped (count stays 4). Same-cycle lookup+resolve when full -> count=3, no push.
- Push+pop every cycle for 10 cycles with alternating outcomes -> count constant, pointers wrap past 3→0, mispredict matches each popped prediction.
- Resolve with count=0 -> resolve_err pulses 1 cycle, mispredict=0, all table entries unchanged.
- With count=3, assert flush together with resolve_taken=1 and lookup_valid -> head entry trained, mispredict per head prediction, count=0 next cycle, lookup not recorded. Mid-run async reset -> count=0 and mispredict=0 immediately, all entries read 0.

Source files
------------

// File: rtl/branch_pred_table.sv
// One-bit taken/not-taken predictor table indexed by fetch PC. An in-order FIFO of
// in-flight predictions is resolved by execute, which trains the table and flags mispredicts.
module branch_pred_table #(
   parameter int unsigned PC_WIDTH   = 32,
   parameter int unsigned INDEX_BITS = 6,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          lookup_valid,
   input  logic [PC_WIDTH-1:0]           lookup_pc,
   output logic                          lookup_ready,
   output logic                          pred_taken,
   input  logic                          resolve_valid,
   input  logic                          resolve_taken,
   input  logic                          flush,
   output logic                          mispredict,
   output logic                          resolve_err,
   output logic [$clog2(FIFO_DEPTH):0]   inflight_count
);

   localparam int unsigned Entries = 2 ** INDEX_BITS;
   localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW    = PtrW + 1;

   logic [Entries-1:0]    r_table;
   logic [INDEX_BITS-1:0] r_fifo_idx  [FIFO_DEPTH];
   logic                  r_fifo_pred [FIFO_DEPTH];
   logic [PtrW-1:0]       r_head;
   logic [PtrW-1:0]       r_tail;
   logic [CntW-1:0]       r_count;
   logic [CntW-1:0]       w_count_d;
   logic                  r_mispredict;
   logic                  r_resolve_err;

   logic [INDEX_BITS-1:0] w_idx;
   logic                  w_empty;
   logic                  w_push;
   logic                  w_pop;
   logic [INDEX_BITS-1:0] w_head_idx;
   logic                  w_head_pred;
   logic                  w_unused_pc_bits;

   assign w_idx            = lookup_pc[INDEX_BITS+1:2];
   assign w_unused_pc_bits = ^{lookup_pc[PC_WIDTH-1:INDEX_BITS+2], lookup_pc[1:0]};

   assign w_empty      = (r_count == '0);
   assign lookup_ready = (r_count < CntW'(FIFO_DEPTH));
   assign pred_taken   = r_table[w_idx];

   // A flushing lookup is never recorded; a flushing resolve still pops and trains.
   assign w_push      = lookup_valid & lookup_ready & ~flush;
   assign w_pop       = resolve_valid & ~w_empty;
   assign w_head_idx  = r_fifo_idx[r_head];
   assign w_head_pred = r_fifo_pred[r_head];

   always_comb begin
      w_count_d = r_count;
      if (flush) begin
         w_count_d = '0;
      end else if (w_push && !w_pop) begin
         w_count_d = r_count + CntW'(1);
      end else if (!w_push && w_pop) begin
         w_count_d = r_count - CntW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_table       <= '0;
         r_head        <= '0;
         r_tail        <= '0;
         r_count       <= '0;
         r_mispredict  <= 1'b0;
         r_resolve_err <= 1'b0;
      end else begin
         r_count       <= w_count_d;
         r_mispredict  <= w_pop & (w_head_pred != resolve_taken);
         r_resolve_err <= resolve_valid & w_empty;
         if (w_pop) begin
            r_table[w_head_idx] <= resolve_taken;
         end
         if (flush) begin
            r_head <= '0;
            r_tail <= '0;
         end else begin
            if (w_pop)  r_head <= r_head + PtrW'(1);
            if (w_push) r_tail <= r_tail + PtrW'(1);
         end
      end
   end

   // Payload storage needs no reset: occupancy alone decides which slots are live.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_idx[r_tail]  <= w_idx;
         r_fifo_pred[r_tail] <= pred_taken;
      end
   end

   assign mispredict     = r_mispredict;
   assign resolve_err    = r_resolve_err;
   assign inflight_count = r_count;

endmodule

// File: tb/tb_branch_pred_table.sv
// Directed bench for branch_pred_table: training, aliasing, full FIFO, wrap, empty resolve,
// flush and asynchronous reset.
module tb_branch_pred_table;

   localparam int unsigned PC_WIDTH   = 32;
   localparam int unsigned INDEX_BITS = 6;
   localparam int unsigned FIFO_DEPTH = 4;

   logic                clk;
   logic                reset;
   logic                lookup_valid;
   logic [PC_WIDTH-1:0] lookup_pc;
   logic                lookup_ready;
   logic                pred_taken;
   logic                resolve_valid;
   logic                resolve_taken;
   logic                flush;
   logic                mispredict;
   logic                resolve_err;
   logic [2:0]          inflight_count;

   int n_checks = 0;
   int n_errors = 0;

   branch_pred_table #(
      .PC_WIDTH  (PC_WIDTH),
      .INDEX_BITS(INDEX_BITS),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_dut (
      .clk           (clk),
      .reset         (reset),
      .lookup_valid  (lookup_valid),
      .lookup_pc     (lookup_pc),
      .lookup_ready  (lookup_ready),
      .pred_taken    (pred_taken),
      .resolve_valid (resolve_valid),
      .resolve_taken (resolve_taken),
      .flush         (flush),
      .mispredict    (mispredict),
      .resolve_err   (resolve_err),
      .inflight_count(inflight_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic lv, input logic [31:0] pc, input logic rv, input logic rt,
                        input logic fl);
      lookup_valid  = lv;
      lookup_pc     = pc;
      resolve_valid = rv;
      resolve_taken = rt;
      flush         = fl;
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic peek(input string tag, input logic [31:0] pc, input logic exp);
      lookup_pc = pc;
      #1;
      check(tag, pred_taken, exp);
   endtask

   bit mq[$];
   bit tbl8;
   bit exp_mis;

   initial begin
      reset = 1'b1;
      idle();
      #12;
      check("rst_count", inflight_count, 0);
      check("rst_mis", mispredict, 0);
      check("rst_err", resolve_err, 0);
      check("rst_ready", lookup_ready, 1);
      reset = 1'b0;
      tick();

      // Train idx 16 from not-taken to taken.
      drive(1, 32'h40, 0, 0, 0);
      #1;
      check("t1_pred0", pred_taken, 0);
      tick();
      check("t1_count1", inflight_count, 1);
      drive(0, 32'h40, 1, 1, 0);
      tick();
      idle();
      check("t1_mis", mispredict, 1);
      check("t1_count0", inflight_count, 0);
      peek("t1_pred1", 32'h40, 1);
      tick();
      check("t1_mis_clear", mispredict, 0);

      // Aliasing 0x40 / 0x140 on idx 16.
      drive(1, 32'h40, 0, 0, 0);
      tick();
      drive(1, 32'h140, 0, 0, 0);
      tick();
      drive(0, 32'h0, 1, 1, 0);
      tick();
      idle();
      check("al_mis0", mispredict, 0);
      peek("al_pred140", 32'h140, 1);
      drive(0, 32'h0, 1, 0, 0);
      tick();
      idle();
      check("al_mis1", mispredict, 1);
      peek("al_pred40", 32'h40, 0);
      check("al_count", inflight_count, 0);
      tick();

      // Fill to capacity, drop an extra lookup, then lookup+resolve while full.
      for (int i = 0; i < 4; i++) begin
         drive(1, 32'(i * 4), 0, 0, 0);
         tick();
      end
      idle();
      check("full_ready", lookup_ready, 0);
      check("full_count", inflight_count, 4);
      drive(1, 32'h10, 0, 0, 0);
      tick();
      check("drop_count", inflight_count, 4);
      drive(1, 32'h10, 1, 0, 0);
      #1;
      check("full_rs_ready", lookup_ready, 0);
      tick();
      idle();
      check("full_rs_count", inflight_count, 3);
      check("full_rs_mis", mispredict, 0);
      for (int i = 0; i < 3; i++) begin
         drive(0, 32'h0, 1, 0, 0);
         tick();
      end
      idle();
      check("drain_count", inflight_count, 0);

      // Steady push+pop on idx 8 with occupancy 2 and alternating outcomes.
      tbl8 = 1'b0;
      for (int i = 0; i < 2; i++) begin
         drive(1, 32'h20, 0, 0, 0);
         tick();
         mq.push_back(tbl8);
      end
      for (int k = 0; k < 10; k++) begin
         drive(1, 32'h20, 1, k[0], 0);
         #1;
         check($sformatf("pp_pred%0d", k), pred_taken, tbl8);
         exp_mis = (mq[0] != k[0]);
         void'(mq.pop_front());
         mq.push_back(tbl8);
         tbl8 = k[0];
         tick();
         check($sformatf("pp_mis%0d", k), mispredict, exp_mis);
         check($sformatf("pp_count%0d", k), inflight_count, 2);
      end
      for (int i = 0; i < 2; i++) begin
         drive(0, 32'h0, 1, 0, 0);
         exp_mis = (mq[0] != 1'b0);
         void'(mq.pop_front());
         tick();
         check($sformatf("pp_drain_mis%0d", i), mispredict, exp_mis);
      end
      idle();
      check("pp_count_end", inflight_count, 0);

      // Resolve with nothing in flight.
      drive(0, 32'h0, 1, 1, 0);
      tick();
      idle();
      check("er_err", resolve_err, 1);
      check("er_mis", mispredict, 0);
      check("er_count", inflight_count, 0);
      tick();
      check("er_err_clear", resolve_err, 0);
      for (int i = 0; i < 64; i++) peek($sformatf("er_tbl%0d", i), 32'(i * 4), 0);
      tick();

      // Flush with a resolve and a lookup in the same cycle.
      for (int i = 0; i < 3; i++) begin
         drive(1, 32'h50 + 32'(i * 4), 0, 0, 0);
         tick();
      end
      drive(1, 32'h5C, 1, 1, 1);
      tick();
      idle();
      check("fl_mis", mispredict, 1);
      check("fl_count", inflight_count, 0);
      check("fl_err", resolve_err, 0);
      check("fl_ready", lookup_ready, 1);
      peek("fl_pred50", 32'h50, 1);
      peek("fl_pred54", 32'h54, 0);
      tick();
      drive(0, 32'h0, 1, 0, 0);
      tick();
      idle();
      check("fl_post_err", resolve_err, 1);
      drive(1, 32'h50, 0, 0, 0);
      tick();
      drive(0, 32'h0, 1, 1, 0);
      tick();
      idle();
      check("fl_retain_mis", mispredict, 0);

      // Asynchronous reset between edges.
      drive(1, 32'h60, 0, 0, 0);
      tick();
      drive(1, 32'h64, 0, 0, 0);
      tick();
      drive(0, 32'h0, 1, 1, 0);
      tick();
      idle();
      check("ar_mis_pre", mispredict, 1);
      check("ar_count_pre", inflight_count, 1);
      #2;
      reset = 1'b1;
      #1;
      check("ar_count", inflight_count, 0);
      check("ar_mis", mispredict, 0);
      check("ar_ready", lookup_ready, 1);
      for (int i = 0; i < 64; i++) peek($sformatf("ar_tbl%0d", i), 32'(i * 4), 0);
      reset = 1'b0;
      tick();
      drive(1, 32'h50, 0, 0, 0);
      #1;
      check("ar_pred50", pred_taken, 0);
      tick();
      idle();
      check("ar_count_after", inflight_count, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
